// File: rtl/instr_input_buffer.sv
// -----------------------------------------------------------------------------
// instr_input_buffer
//
// Front-end input stage of the 8-bit HDU-RISC hazard demonstrator. Instruction
// words set on the board switches are captured into a small in-order buffer
// whenever the debounced LOAD button is pressed. The buffer is read at random
// by the downstream hazard checker. A debounced CLEAR button empties it.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   sw_instr   in   [DATA_W]  switch word, sampled on the write edge
//   btn_load   in   raw, bouncing LOAD button
//   btn_clear  in   raw, bouncing CLEAR button
//   lock       in   checker busy; load events are discarded while high
//   rd_addr    in   [PTR_W]   read slot index
//   rd_data    out  [DATA_W]  mem[rd_addr] when rd_addr < count, else 0
//   count      out  [PTR_W+1] number of valid instructions, 0..DEPTH
//   empty      out  count == 0
//   full       out  count == DEPTH
//   load_ack   out  one-cycle pulse in the cycle after an accepted write
//   overflow   out  sticky; a load was attempted while full
//
// Handshake: there is no valid/ready pair on this block. A load "event" is the
// debounced 0->1 edge of LOAD. It is either accepted (written, acknowledged by
// exactly one load_ack cycle) or discarded (clear on the same edge, lock high,
// or buffer full -- the last also sets overflow). No event is ever queued.
// -----------------------------------------------------------------------------

// Synchroniser plus debouncer for one button. rise_o is high during the cycle
// whose closing edge moves the debounced level from 0 to 1.
module instr_input_buffer_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o,
  output logic deb_o
);
  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (s2_q == deb_q) begin
      // Any agreeing cycle restarts the stability window.
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign rise_o = ~deb_q & deb_d;
  assign deb_o  = deb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= btn_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module instr_input_buffer #(
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3,
  parameter int DATA_W     = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw_instr,
  input  logic              btn_load,
  input  logic              btn_clear,
  input  logic              lock,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              load_ack,
  output logic              overflow
);
  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic              load_fire, clear_fire;
  logic              load_deb, clear_deb;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              ack_q, ack_d;
  logic              we;

  instr_input_buffer_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_load),
    .rise_o (load_fire),
    .deb_o  (load_deb)
  );

  instr_input_buffer_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_clear),
    .rise_o (clear_fire),
    .deb_o  (clear_deb)
  );

  // Debounced levels are only needed for the falling-edge re-arm inside the
  // debouncers; they are kept visible for probing.
  logic unused_deb;
  assign unused_deb = load_deb ^ clear_deb;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);

  // Clear outranks load; lock only gates loads, never clears.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    ack_d      = 1'b0;
    we         = 1'b0;
    if (clear_fire) begin
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (load_fire && !lock) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = count_q + (PTR_W + 1)'(1);
        ack_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ack_q      <= ack_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wr_ptr_q] <= sw_instr;
    end
  end

  // Stale entries beyond count (e.g. after a clear) are masked to zero.
  assign rd_data  = ({1'b0, rd_addr} < count_q) ? mem_q[rd_addr] : '0;
  assign count    = count_q;
  assign load_ack = ack_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_instr_input_buffer.sv
module tb_instr_input_buffer;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int DATA_W = 8;
  localparam int DEB    = 4;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] sw_instr;
  logic              btn_load;
  logic              btn_clear;
  logic              lock;
  logic [PTR_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [PTR_W:0]    count;
  logic              empty;
  logic              full;
  logic              load_ack;
  logic              overflow;

  instr_input_buffer #(
    .DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W), .DEB_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw_instr  (sw_instr),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .lock      (lock),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .load_ack  (load_ack),
    .overflow  (overflow)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 ns");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned ack_cnt = 0;
  int          m_count = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every accepted write must match the oldest pending expectation. The
  // driver points rd_addr at the slot being written before each press.
  always @(negedge clk) begin
    if (!reset && load_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) check("unexpected_ack", 32'(1), 32'(0));
      else check("ack_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  // Advance to just after the next falling edge: inputs change and outputs
  // are sampled there, half a period away from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic press_load(input logic [DATA_W-1:0] val, input bit expect_write);
    sw_instr = val;
    if (expect_write) begin
      rd_addr = PTR_W'(m_count);
      exp_q.push_back(val);
      m_count++;
    end
    btn_load = 1'b1;
    repeat (8) tick();
    btn_load = 1'b0;
    repeat (8) tick();
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    repeat (8) tick();
    btn_clear = 1'b0;
    repeat (8) tick();
    m_count = 0;
  endtask

  // Press LOAD from a fresh debounce and require the ack exactly on the
  // sixth sample (fire at E0+1+DEB, ack visible in the following cycle).
  task automatic press_timed(input string tag, input logic [DATA_W-1:0] val);
    int unsigned a0;
    sw_instr = val;
    rd_addr  = PTR_W'(m_count);
    exp_q.push_back(val);
    m_count++;
    btn_load = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == DEB + 1 || k == DEB + 2 || k == DEB + 3)
        check(tag, 32'(load_ack), 32'(k == DEB + 2));
    end
    a0 = ack_cnt;
    btn_load = 1'b0;
    repeat (8) tick();
    check({tag, "_no_extra_ack"}, 32'(ack_cnt), 32'(a0));
  endtask

  // ---------------- test sequence ----------------
  int unsigned a_before;
  logic [DATA_W-1:0] rnd;

  initial begin
    reset = 1'b1; sw_instr = '0; btn_load = 1'b0; btn_clear = 1'b0;
    lock = 1'b0; rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_count", 32'(count), 32'(0));
    check("rst_empty", 32'(empty), 32'(1));
    check("rst_full", 32'(full), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    check("rst_load_ack", 32'(load_ack), 32'(0));

    // Single held press of A3: one write at E5, one ack
    press_timed("a3_ack_timing", 8'hA3);
    check("a3_count", 32'(count), 32'(1));
    check("a3_empty", 32'(empty), 32'(0));
    rd_addr = 3'd0; #1;
    check("a3_rd0", 32'(rd_data), 32'(8'hA3));
    rd_addr = 3'd1; #1;
    check("a3_rd1_masked", 32'(rd_data), 32'(0));

    // Bounce 1,0,1,1,0 then stable high: exactly one write after final rise
    a_before = ack_cnt;
    sw_instr = 8'h3C;
    btn_load = 1'b1; tick();
    btn_load = 1'b0; tick();
    btn_load = 1'b1; tick();
    btn_load = 1'b1; tick();
    btn_load = 1'b0; tick();
    check("bounce_no_early_ack", 32'(ack_cnt), 32'(a_before));
    press_timed("bounce_ack_timing", 8'h3C);
    check("bounce_count", 32'(count), 32'(2));

    // Clear, then fill with 10..17
    press_clear();
    check("clr_count", 32'(count), 32'(0));
    rd_addr = 3'd0; #1;
    check("clr_rd0_masked", 32'(rd_data), 32'(0));
    for (int i = 0; i < DEPTH; i++) press_load(8'h10 + 8'(i), 1'b1);
    check("fill_full", 32'(full), 32'(1));
    check("fill_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr = PTR_W'(i); #1;
      check("fill_readback", 32'(rd_data), 32'(8'h10 + 8'(i)));
    end
    // Ninth press while full
    a_before = ack_cnt;
    press_load(8'hFF, 1'b0);
    check("ovf_flag", 32'(overflow), 32'(1));
    check("ovf_no_ack", 32'(ack_cnt), 32'(a_before));
    check("ovf_count", 32'(count), 32'(DEPTH));
    rd_addr = 3'd0; #1;
    check("ovf_slot0", 32'(rd_data), 32'(8'h10));

    // Clear resets overflow; lock discards a press silently
    press_clear();
    check("clr2_overflow", 32'(overflow), 32'(0));
    check("clr2_empty", 32'(empty), 32'(1));
    lock = 1'b1;
    a_before = ack_cnt;
    press_load(8'h55, 1'b0);
    check("lock_count", 32'(count), 32'(0));
    check("lock_no_ack", 32'(ack_cnt), 32'(a_before));
    check("lock_overflow", 32'(overflow), 32'(0));
    lock = 1'b0;
    press_load(8'h55, 1'b1);
    check("unlock_count", 32'(count), 32'(1));

    // Two random words to reach count=3, then both buttons together
    for (int i = 0; i < 2; i++) begin
      rnd = 8'($urandom_range(1, 255));
      press_load(rnd, 1'b1);
    end
    check("pre_both_count", 32'(count), 32'(3));
    a_before = ack_cnt;
    sw_instr = 8'h99;
    btn_load = 1'b1; btn_clear = 1'b1;
    repeat (8) tick();
    btn_load = 1'b0; btn_clear = 1'b0;
    repeat (8) tick();
    m_count = 0;
    check("both_count", 32'(count), 32'(0));
    check("both_overflow", 32'(overflow), 32'(0));
    check("both_no_ack", 32'(ack_cnt), 32'(a_before));
    rd_addr = 3'd0; #1;
    check("both_rd0", 32'(rd_data), 32'(0));

    // Clear honoured while locked
    press_load(8'h42, 1'b1);
    lock = 1'b1;
    press_clear();
    check("lock_clear_count", 32'(count), 32'(0));
    lock = 1'b0;

    // Reset during the 3rd debounce cycle with LOAD still held
    press_load(8'h77, 1'b1);
    sw_instr = 8'hC6;
    btn_load = 1'b1;
    repeat (4) tick();
    reset = 1'b1; #1;
    check("mid_rst_count", 32'(count), 32'(0));
    check("mid_rst_empty", 32'(empty), 32'(1));
    check("mid_rst_rd_data", 32'(rd_data), 32'(0));
    check("mid_rst_ack", 32'(load_ack), 32'(0));
    tick(); tick();
    m_count = 0;
    reset = 1'b0;
    rd_addr = 3'd0;
    exp_q.push_back(8'hC6);
    m_count = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == DEB + 1 || k == DEB + 2 || k == DEB + 3)
        check("post_rst_ack_timing", 32'(load_ack), 32'(k == DEB + 2));
    end
    btn_load = 1'b0;
    repeat (8) tick();
    check("post_rst_count", 32'(count), 32'(1));
    check("post_rst_rd0", 32'(rd_data), 32'(8'hC6));

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
